// File: rtl/io_resp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | io_resp_pkg                                                        |
// | Shared types and constants for the I/O port responder: FSM state,  |
// | port offsets, status bit positions and FIFO depth.                 |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package io_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [1:0] OFF_DATA = 2'd0;
  localparam logic [1:0] OFF_STAT = 2'd1;
  localparam logic [1:0] OFF_CTRL = 2'd2;
  localparam logic [1:0] OFF_SCR  = 2'd3;

  localparam int STAT_OVF   = 7;
  localparam int STAT_UDF   = 6;
  localparam int FIFO_DEPTH = 4;

  localparam logic [7:0] EMPTY_READ = 8'hFF;

  // Assemble the status byte: sticky flags on top, occupancy in the low bits.
  function automatic logic [7:0] status_byte(input logic ovf, input logic udf,
                                             input logic [2:0] cnt);
    logic [7:0] s;
    s           = 8'h00;
    s[STAT_OVF] = ovf;
    s[STAT_UDF] = udf;
    s[2:0]      = cnt;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_fifo4.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | io_fifo4                                                           |
// | Four-entry byte FIFO. A pop and a push in the same cycle are both  |
// | honoured; a push into a full FIFO lands only if a pop frees a slot.|
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module io_fifo4
  import io_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] push_data,
  output logic [7:0] data,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [FIFO_DEPTH];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic       do_pop;
  logic       do_push;

  assign empty   = (count == 3'd0);
  assign full    = (count == 3'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign data    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; pointers wrap naturally at depth four.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      count <= count + 3'(do_push) - 3'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_port_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | io_port_responder                                                  |
// | Four-port I/O slave with wait-state insertion: FIFO data port,     |
// | status port, control latch and scratch register.                   |
// | Optional feature macro: IO_PARITY_EN adds the rd_parity output.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module io_port_responder
  import io_resp_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR   = 8'hDC,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iorq,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       io_wait,
  output logic       io_ack,
  input  logic [7:0] dev_data,
  input  logic       dev_valid,
  output logic [7:0] ctrl_out
`ifdef IO_PARITY_EN
  ,
  output logic       rd_parity
`endif
);

  state_t     state;
  state_t     state_next;
  logic [2:0] wcnt;
  logic       last_wait;

  logic [1:0] cap_off;
  logic       cap_wr;
  logic [7:0] cap_din;

  logic [7:0] scratch;
  logic [7:0] hold_data;
  logic [7:0] rd_value;
  logic       ovf;
  logic       udf;

  logic [8:0] addr_rel;
  logic       in_range;
  logic       accept;
  logic       do_ack;
  logic       pop_req;
  logic       ovf_set;
  logic       udf_set;

  logic [7:0] fifo_data;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;

  // Nine-bit subtraction so an address below BASE wraps far out of range.
  assign addr_rel  = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign in_range  = (addr_rel < 9'd4);
  assign accept    = iorq && (rd ^ wr) && in_range;
  assign last_wait = (wcnt == 3'(WAIT_CYCLES - 1));

  assign do_ack  = (state == ACK);
  assign pop_req = do_ack && !cap_wr && (cap_off == OFF_DATA);
  assign udf_set = pop_req && fifo_empty;
  assign ovf_set = dev_valid && fifo_full && !pop_req;

  io_fifo4 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (dev_valid),
    .pop       (pop_req),
    .push_data (dev_data),
    .data      (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register, wait counter and capture of the accepted bus request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      wcnt    <= 3'd0;
      cap_off <= 2'd0;
      cap_wr  <= 1'b0;
      cap_din <= 8'h00;
    end else begin
      state <= state_next;
      wcnt  <= (state == WAIT) ? wcnt + 3'd1 : 3'd0;
      if ((state == IDLE) && accept) begin
        cap_off <= addr_rel[1:0];
        cap_wr  <= wr;
        cap_din <= din;
      end
    end
  end

  // Next-state logic; dropping iorq in WAIT abandons the access.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (WAIT_CYCLES == 0) ? ACK : WAIT;
      WAIT: begin
        if (!iorq)          state_next = IDLE;
        else if (last_wait) state_next = ACK;
      end
      ACK:  state_next = HOLD;
      HOLD: if (!iorq) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read mux from pre-edge state, so status returns pre-clear flags.
  always_comb begin
    rd_value = 8'h00;
    if (!cap_wr) begin
      case (cap_off)
        OFF_DATA: rd_value = fifo_empty ? EMPTY_READ : fifo_data;
        OFF_STAT: rd_value = status_byte(ovf, udf, fifo_count);
        OFF_CTRL: rd_value = ctrl_out;
        OFF_SCR:  rd_value = scratch;
        default:  rd_value = 8'h00;
      endcase
    end
  end

  // Register writes, read-data hold and sticky flags, all at the ACK edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_out  <= 8'h00;
      scratch   <= 8'h00;
      hold_data <= 8'h00;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      if (do_ack) begin
        hold_data <= rd_value;
        if (cap_wr && (cap_off == OFF_CTRL)) ctrl_out <= cap_din;
        if (cap_wr && (cap_off == OFF_SCR))  scratch  <= cap_din;
        if (!cap_wr && (cap_off == OFF_STAT)) begin
          ovf <= 1'b0;
          udf <= 1'b0;
        end
      end
      // A new event in the clearing cycle still wins over the clear.
      if (ovf_set) ovf <= 1'b1;
      if (udf_set) udf <= 1'b1;
    end
  end

  assign io_wait = (state == WAIT);
  assign io_ack  = (state == ACK);
  assign dout    = (state == ACK)  ? rd_value  :
                   (state == HOLD) ? hold_data : 8'h00;

`ifdef IO_PARITY_EN
  assign rd_parity = ((state == ACK) || (state == HOLD)) ? ~^dout : 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_port_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_io_port_responder                                               |
// | Self-checking bench: directed scenarios plus randomized traffic    |
// | against a queue-based reference model.                             |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_io_port_responder;

  localparam logic [7:0] BASE = 8'hDC;
  localparam int         WC   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iorq = 1'b0, rd = 1'b0, wr = 1'b0, dev_valid = 1'b0;
  logic [7:0] addr = 8'h00, din = 8'h00, dev_data = 8'h00;
  logic [7:0] dout, ctrl_out, dout0, ctrl_out0;
  logic       io_wait, io_ack, io_wait0, io_ack0;
  logic       rd_parity, rd_parity0;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_q[$];
  bit         m_ovf, m_udf;
  logic [7:0] m_ctrl, m_scr;

  // Observations from the last bus access
  int         o_ack_cyc, o_wait_cnt, o_ack0_cyc;
  logic [7:0] o_rdata, o_hold_dout, o_idle_dout;
  logic       o_par, o_hold_ack;

  always #5 clk = ~clk;

  io_port_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n), .iorq(iorq), .rd(rd), .wr(wr), .addr(addr),
    .din(din), .dout(dout), .io_wait(io_wait), .io_ack(io_ack),
    .dev_data(dev_data), .dev_valid(dev_valid), .ctrl_out(ctrl_out)
`ifdef IO_PARITY_EN
    , .rd_parity(rd_parity)
`endif
  );

  io_port_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .iorq(iorq), .rd(rd), .wr(wr), .addr(addr),
    .din(din), .dout(dout0), .io_wait(io_wait0), .io_ack(io_ack0),
    .dev_data(dev_data), .dev_valid(dev_valid), .ctrl_out(ctrl_out0)
`ifdef IO_PARITY_EN
    , .rd_parity(rd_parity0)
`endif
  );

`ifndef IO_PARITY_EN
  assign rd_parity  = 1'b0;
  assign rd_parity0 = 1'b0;
`endif

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_q.delete();
    m_ovf = 0; m_udf = 0; m_ctrl = 8'h00; m_scr = 8'h00;
  endfunction

  function automatic void model_push(input logic [7:0] d);
    if (m_q.size() < 4) m_q.push_back(d);
    else m_ovf = 1;
  endfunction

  // One access; an optional device push in the same cycle is applied after the pop.
  function automatic logic [7:0] model_access(input bit is_wr, input logic [1:0] off,
                                              input logic [7:0] wdata, input bit push,
                                              input logic [7:0] pdata);
    logic [7:0] rv;
    rv = 8'h00;
    if (is_wr) begin
      if (off == 2'd2) m_ctrl = wdata;
      else if (off == 2'd3) m_scr = wdata;
    end else begin
      case (off)
        2'd0: if (m_q.size() == 0) begin rv = 8'hFF; m_udf = 1; end
              else rv = m_q.pop_front();
        2'd1: begin
          rv = {m_ovf, m_udf, 3'b000, 3'(m_q.size())};
          m_ovf = 0; m_udf = 0;
        end
        2'd2: rv = m_ctrl;
        default: rv = m_scr;
      endcase
    end
    if (push) model_push(pdata);
    return rv;
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic dev_push(input logic [7:0] d);
    @(negedge clk);
    dev_valid = 1; dev_data = d;
    @(negedge clk);
    dev_valid = 0;
    model_push(d);
  endtask

  task automatic bus_access(input bit is_wr, input logic [1:0] off, input logic [7:0] wdata,
                            input bit push_at_ack, input logic [7:0] pdata);
    @(negedge clk);
    iorq = 1; rd = !is_wr; wr = is_wr; addr = 8'(BASE + 8'(off)); din = wdata;
    o_ack_cyc = 0; o_wait_cnt = 0; o_ack0_cyc = 0; o_rdata = 8'hxx; o_par = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Disturb the bus after acceptance; the captured request must stand.
        addr = 8'($urandom); din = 8'($urandom); rd = ~rd; wr = ~wr;
      end
      if (io_wait) o_wait_cnt++;
      if (io_ack0 && o_ack0_cyc == 0) o_ack0_cyc = c;
      if (io_ack) begin
        o_ack_cyc = c; o_rdata = dout; o_par = rd_parity;
        if (push_at_ack) begin dev_valid = 1; dev_data = pdata; end
        break;
      end
    end
    @(negedge clk);
    dev_valid = 0;
    o_hold_dout = dout; o_hold_ack = io_ack;
    iorq = 0; rd = 0; wr = 0;
    @(negedge clk);
    o_idle_dout = dout;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++; if (io_wait !== 1'b0) begin bad++; $display("FAIL reset_wait: got %b want 0", io_wait); end
    total++; if (io_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", io_ack); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", dout); end
    total++; if (ctrl_out !== 8'h00) begin bad++; $display("FAIL reset_ctrl: got %h want 00", ctrl_out); end
    total++; if (rd_parity !== 1'b0) begin bad++; $display("FAIL reset_parity: got %b want 0", rd_parity); end
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_ctrl_write();
    logic [7:0] exp;
    bus_access(1, 2'd2, 8'h5A, 0, 8'h00);
    exp = model_access(1, 2'd2, 8'h5A, 0, 8'h00);
    total++; if (o_ack_cyc != WC + 1) begin bad++; $display("FAIL ctrl_ack_cycle: got %0d want %0d", o_ack_cyc, WC + 1); end
    total++; if (o_wait_cnt != WC) begin bad++; $display("FAIL ctrl_wait_len: got %0d want %0d", o_wait_cnt, WC); end
    total++; if (o_ack0_cyc != 1) begin bad++; $display("FAIL zero_wait_ack_cycle: got %0d want 1", o_ack0_cyc); end
    total++; if (ctrl_out !== 8'h5A) begin bad++; $display("FAIL ctrl_out: got %h want 5a", ctrl_out); end
    total++; if (o_hold_ack !== 1'b0) begin bad++; $display("FAIL ack_one_cycle: got %b want 0", o_hold_ack); end
    total++; if (o_idle_dout !== 8'h00) begin bad++; $display("FAIL idle_dout: got %h want 00", o_idle_dout); end
    m_ctrl = exp | m_ctrl;
  endtask

  task automatic test_fifo_read();
    logic [7:0] exp;
    logic [1:0] offs [3] = '{2'd0, 2'd0, 2'd1};
    dev_push(8'h11);
    dev_push(8'h22);
    foreach (offs[i]) begin
      bus_access(0, offs[i], 8'h00, 0, 8'h00);
      exp = model_access(0, offs[i], 8'h00, 0, 8'h00);
      total++; if (o_rdata !== exp) begin bad++; $display("FAIL fifo_read%0d: got %h want %h", i, o_rdata, exp); end
      total++; if (o_hold_dout !== exp) begin bad++; $display("FAIL fifo_hold%0d: got %h want %h", i, o_hold_dout, exp); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) dev_push(8'(8'h30 + i));
    for (int i = 0; i < 2; i++) begin
      bus_access(0, 2'd1, 8'h00, 0, 8'h00);
      exp = model_access(0, 2'd1, 8'h00, 0, 8'h00);
      total++; if (o_rdata !== exp) begin bad++; $display("FAIL ovf_status%0d: got %h want %h", i, o_rdata, exp); end
    end
    for (int i = 0; i < 4; i++) begin
      bus_access(0, 2'd0, 8'h00, 0, 8'h00);
      exp = model_access(0, 2'd0, 8'h00, 0, 8'h00);
      total++; if (o_rdata !== exp) begin bad++; $display("FAIL ovf_drain%0d: got %h want %h", i, o_rdata, exp); end
    end
  endtask

  task automatic test_underflow();
    logic [7:0] exp;
    bus_access(0, 2'd0, 8'h00, 0, 8'h00);
    exp = model_access(0, 2'd0, 8'h00, 0, 8'h00);
    total++; if (o_rdata !== exp) begin bad++; $display("FAIL udf_read: got %h want %h", o_rdata, exp); end
`ifdef IO_PARITY_EN
    total++; if (o_par !== ~^exp) begin bad++; $display("FAIL udf_parity: got %b want %b", o_par, ~^exp); end
`endif
    bus_access(0, 2'd1, 8'h00, 0, 8'h00);
    exp = model_access(0, 2'd1, 8'h00, 0, 8'h00);
    total++; if (o_rdata !== exp) begin bad++; $display("FAIL udf_status: got %h want %h", o_rdata, exp); end
  endtask

  task automatic test_abort();
    logic [7:0] exp;
    bit         seen;
    logic [10:0] pats [5];
    pats[0] = {1'b1, 1'b1, 1'b0, 8'h50};
    pats[1] = {1'b1, 1'b1, 1'b1, 8'(BASE + 8'd3)};
    pats[2] = {1'b0, 1'b0, 1'b1, 8'(BASE + 8'd2)};
    pats[3] = {1'b1, 1'b0, 1'b1, 8'(BASE - 8'd1)};
    pats[4] = {1'b1, 1'b0, 1'b1, 8'(BASE + 8'd4)};
    @(negedge clk);
    iorq = 1; wr = 1; rd = 0; addr = 8'(BASE + 8'd3); din = 8'hAA;
    @(negedge clk);
    total++; if (io_wait !== 1'b1) begin bad++; $display("FAIL abort_in_wait: got %b want 1", io_wait); end
    iorq = 0; wr = 0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (io_ack) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL abort_ack: got 1 want 0"); end
    bus_access(0, 2'd3, 8'h00, 0, 8'h00);
    exp = model_access(0, 2'd3, 8'h00, 0, 8'h00);
    total++; if (o_rdata !== exp) begin bad++; $display("FAIL abort_scratch: got %h want %h", o_rdata, exp); end
    foreach (pats[i]) begin
      @(negedge clk);
      {iorq, rd, wr, addr} = pats[i]; din = 8'hE7;
      seen = 0;
      for (int c = 0; c < 5; c++) begin @(negedge clk); if (io_wait || io_ack) seen = 1; end
      iorq = 0; rd = 0; wr = 0;
      total++; if (seen) begin bad++; $display("FAIL ignore_pat%0d: got wait/ack want none", i); end
      total++; if (ctrl_out !== m_ctrl) begin bad++; $display("FAIL ignore_ctrl%0d: got %h want %h", i, ctrl_out, m_ctrl); end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    // Empty FIFO: the pop returns FF while the push still lands.
    bus_access(0, 2'd0, 8'h00, 1, 8'h77);
    exp = model_access(0, 2'd0, 8'h00, 1, 8'h77);
    total++; if (o_rdata !== exp) begin bad++; $display("FAIL simul_empty: got %h want %h", o_rdata, exp); end
    for (int i = 0; i < 3; i++) dev_push(8'(8'hA0 + i));
    // Full FIFO: pop frees a slot so the push is accepted.
    bus_access(0, 2'd0, 8'h00, 1, 8'h99);
    exp = model_access(0, 2'd0, 8'h00, 1, 8'h99);
    total++; if (o_rdata !== exp) begin bad++; $display("FAIL simul_full: got %h want %h", o_rdata, exp); end
    for (int i = 0; i < 5; i++) begin
      bus_access(0, (i == 0) ? 2'd1 : 2'd0, 8'h00, 0, 8'h00);
      exp = model_access(0, (i == 0) ? 2'd1 : 2'd0, 8'h00, 0, 8'h00);
      total++; if (o_rdata !== exp) begin bad++; $display("FAIL simul_drain%0d: got %h want %h", i, o_rdata, exp); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp, wd, pd;
    logic [1:0] off;
    bit         is_wr, psh;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        dev_push(8'($urandom));
      end else begin
        is_wr = 1'($urandom); off = 2'($urandom); wd = 8'($urandom);
        psh = ($urandom_range(0, 3) == 0); pd = 8'($urandom);
        bus_access(is_wr, off, wd, psh, pd);
        exp = model_access(is_wr, off, wd, psh, pd);
        total++; if (o_ack_cyc != WC + 1) begin bad++; $display("FAIL rnd_ack_cycle%0d: got %0d want %0d", n, o_ack_cyc, WC + 1); end
        total++; if (o_wait_cnt != WC) begin bad++; $display("FAIL rnd_wait_len%0d: got %0d want %0d", n, o_wait_cnt, WC); end
        total++; if (o_ack0_cyc != 1) begin bad++; $display("FAIL rnd_zero_wait%0d: got %0d want 1", n, o_ack0_cyc); end
        total++; if (o_idle_dout !== 8'h00) begin bad++; $display("FAIL rnd_idle_dout%0d: got %h want 00", n, o_idle_dout); end
        total++; if (ctrl_out !== m_ctrl) begin bad++; $display("FAIL rnd_ctrl%0d: got %h want %h", n, ctrl_out, m_ctrl); end
        if (!is_wr) begin
          total++; if (o_rdata !== exp) begin bad++; $display("FAIL rnd_read%0d off%0d: got %h want %h", n, off, o_rdata, exp); end
          total++; if (o_hold_dout !== exp) begin bad++; $display("FAIL rnd_hold%0d: got %h want %h", n, o_hold_dout, exp); end
`ifdef IO_PARITY_EN
          total++; if (o_par !== ~^exp) begin bad++; $display("FAIL rnd_parity%0d: got %b want %b", n, o_par, ~^exp); end
`endif
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    bit         seen;
    @(negedge clk);
    iorq = 1; wr = 1; rd = 0; addr = 8'(BASE + 8'd2); din = 8'h33;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); if (io_ack) seen = 1; end
    @(negedge clk);  // HOLD
    total++; if (ctrl_out !== 8'h33) begin bad++; $display("FAIL rmid_ctrl_before: got %h want 33", ctrl_out); end
    rst_n = 0;
    @(negedge clk);
    iorq = 0; wr = 0; rst_n = 1;
    model_reset();
    total++; if (io_wait !== 1'b0) begin bad++; $display("FAIL rmid_wait: got %b want 0", io_wait); end
    total++; if (io_ack !== 1'b0) begin bad++; $display("FAIL rmid_ack: got %b want 0", io_ack); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL rmid_dout: got %h want 00", dout); end
    total++; if (ctrl_out !== 8'h00) begin bad++; $display("FAIL rmid_ctrl: got %h want 00", ctrl_out); end
    // Reset during WAIT: the access must die without an acknowledge.
    dev_push(8'h5C);
    @(negedge clk);
    iorq = 1; rd = 1; wr = 0; addr = BASE;
    @(negedge clk);
    rst_n = 0; iorq = 0; rd = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    seen = 0;
    for (int c = 0; c < 5; c++) begin @(negedge clk); if (io_ack) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL rwait_ack: got 1 want 0"); end
    bus_access(0, 2'd1, 8'h00, 0, 8'h00);
    exp = model_access(0, 2'd1, 8'h00, 0, 8'h00);
    total++; if (o_rdata !== exp) begin bad++; $display("FAIL rwait_status: got %h want %h", o_rdata, exp); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_ctrl_write();
    test_fifo_read();
    test_overflow();
    test_underflow();
    test_abort();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_port_responder.md
IO_PORT_RESPONDER -- requirements
Module: io_port_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'hDC, the first of four consecutive I/O ports decoded.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, the number of wait-state cycles inserted per access (range 0..7).
REQ-003 SHALL use one clock, clk; reset rst_n is synchronous and active-low.
REQ-004 Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
iorq  in  1  I/O request, active-high
rd  in  1  read strobe, active-high
wr  in  1  write strobe, active-high
addr  in  8  port address
din  in  8  write data from CPU
dout  out  8  read data to CPU
io_wait  out  1  wait request, active-high
io_ack  out  1  one-cycle access-complete pulse
dev_data  in  8  device byte to enqueue
dev_valid  in  1  enqueue strobe
ctrl_out  out  8  control latch
rd_parity  out  1  even-parity flag of dout (IO_PARITY_EN only)

Function
REQ-005 Port map: BASE+0 reads pop the FIFO; BASE+1 reads status; BASE+2 is the read/write ctrl_out latch; BASE+3 is a read/write scratch register; writes to BASE+0 and BASE+1 SHALL be acknowledged and ignored.
REQ-006 A request SHALL be accepted in IDLE only when iorq=1, exactly one of rd/wr=1, and addr is in BASE..BASE+3; any other combination SHALL be ignored without asserting io_wait or io_ack.
REQ-007 FSM states: IDLE, WAIT, ACK, HOLD.
- IDLE->WAIT on an accepted request, or IDLE->ACK when WAIT_CYCLES=0.
- WAIT->ACK after WAIT_CYCLES cycles.
- ACK->HOLD unconditionally.
- HOLD->IDLE when iorq=0.
REQ-008 io_wait SHALL be 1 exactly while in WAIT.
REQ-009 io_ack SHALL be 1 exactly in ACK.
REQ-010 Latency: a request first sampled at edge N SHALL produce io_ack in cycle N+1+WAIT_CYCLES.
REQ-011 Address, rd/wr and din SHALL be captured on acceptance; later bus changes during the access SHALL be ignored.
REQ-012 Register writes and FIFO pops SHALL take effect at the ACK-cycle edge only.
REQ-013 dout SHALL be valid from ACK through HOLD and SHALL be 8'h00 otherwise.
REQ-014 If iorq falls during WAIT, the FSM SHALL return to IDLE with no side effects and no io_ack.
REQ-015 FIFO: 4 entries; dev_valid pushes dev_data each cycle it is high.
REQ-016 A push when the FIFO is full SHALL be dropped and SHALL set sticky status[7] (overflow).
REQ-017 A read of BASE+0 when the FIFO is empty SHALL return 8'hFF, SHALL not pop, and SHALL set sticky status[6] (underflow).
REQ-018 Status byte: [7] overflow, [6] underflow, [5:3] 0, [2:0] count 0..4; a status read SHALL clear [7:6] at the ACK edge and return their pre-clear values.
REQ-019 Simultaneous pop and push SHALL both succeed; empty/full is judged on the pre-cycle state, so a pop from an empty FIFO returns 8'hFF while the push still lands, and a push into a full FIFO is accepted because the pop frees a slot.

Reset
REQ-020 On rst_n=0 at an edge, the module SHALL:
- set state to IDLE;
- drive io_wait=0, io_ack=0, dout=8'h00, ctrl_out=8'h00, rd_parity=0;
- clear scratch to 8'h00;
- clear the FIFO count and pointers to 0;
- clear the sticky flags to 0.
REQ-021 Reset asserted mid-access SHALL abort the access with no register or FIFO side effect and no io_ack.

Configuration
REQ-022 With IO_PARITY_EN defined, rd_parity SHALL equal 1 when dout has even parity during ACK/HOLD, and 0 otherwise.
REQ-023 Without IO_PARITY_EN, the rd_parity port SHALL be absent.

Structure
REQ-024 Package io_resp_pkg SHALL hold the FSM state enum, port offsets (DATA=0, STAT=1, CTRL=2, SCR=3), status bit positions and FIFO depth.
REQ-025 The FIFO SHALL be sub-module io_fifo4 (push, pop, data, count, full, empty); all remaining logic SHALL be in io_port_responder.

Verification
REQ-026 Write 8'h5A to BASE+2 (WAIT_CYCLES=2) -> io_wait high for 2 cycles, io_ack in cycle N+3, ctrl_out=8'h5A after ACK.
REQ-027 Push 8'h11, 8'h22 then read BASE+0 twice and BASE+1 once -> reads return 11, 22, then status 8'h00.
REQ-028 Push 5 bytes, read BASE+1, read BASE+1 again -> first read 8'h84, second read 8'h04.
REQ-029 Read BASE+0 when empty -> returns 8'hFF; next status read 8'h40; rd_parity=1 with IO_PARITY_EN.
REQ-030 Drop iorq mid-WAIT on a BASE+3 write of 8'hAA -> no io_ack, scratch stays 8'h00; access to 8'h50 -> io_wait/io_ack never assert.
REQ-031 Assert rst_n=0 during HOLD of a ctrl write -> outputs return to reset values next cycle; WAIT_CYCLES=0 build -> io_ack in cycle N+1.
